// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp and phase encodings, default timings and phase order shared by the scheduler.
package traffic_pkg;
   typedef enum logic [1:0] {RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10} light_e;
   typedef enum logic [2:0] {NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B} phase_e;
   localparam int D_GREEN_SHORT = 10;
   localparam int D_GREEN_LONG  = 30;
   localparam int D_YELLOW_T    = 3;
   localparam int D_ALLRED_T    = 1;
   localparam int D_EXT_STEP    = 5;
   localparam int D_GREEN_MAX   = 40;
   localparam int D_PED_CUT     = 5;
   localparam int D_CNT_W       = 6;
   function automatic phase_e next_phase(input phase_e p);
      return p == ALLRED_B ? NS_GREEN : phase_e'(p + 3'd1);
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable per-second down-counter; reload replaces the decrement on a tick.
module phase_timer #(
   parameter int CNT_W   = 6,
   parameter int RST_VAL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] remain,
   output logic             at_one
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) remain <= CNT_W'(RST_VAL);
      else if (tick) remain <= load ? load_val : remain - CNT_W'(1);
   assign at_one = remain == CNT_W'(1);
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: NS/EW green-yellow-allred sequencer with density-driven green
// lengths, single-approach green extension and pedestrian truncation.
module intersection_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int GREEN_SHORT = D_GREEN_SHORT,
   parameter int GREEN_LONG  = D_GREEN_LONG,
   parameter int YELLOW_T    = D_YELLOW_T,
   parameter int ALLRED_T    = D_ALLRED_T,
   parameter int EXT_STEP    = D_EXT_STEP,
   parameter int GREEN_MAX   = D_GREEN_MAX,
   parameter int PED_CUT     = D_PED_CUT,
   parameter int CNT_W       = D_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_sec,
   input  logic             ns_dense,
   input  logic             ew_dense,
   input  logic             ped_req,
   output logic [1:0]       ns_light,
   output logic [1:0]       ew_light,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] remain_sec,
   output logic             phase_valid,
   output logic             ped_ack
);
   phase_e state, state_nx;
   light_e ns_nx, ew_nx;
   logic [CNT_W-1:0] elapsed, elapsed_nx, load_val;
   logic ped_pend, ped_nx, ack_nx, at_one, is_green, own, oth, extend, cut, adv;

   phase_timer #(.CNT_W(CNT_W), .RST_VAL(ALLRED_T)) u_timer (
      .clk(clk),
      .reset(reset),
      .tick(tick_sec),
      .load(at_one || cut),
      .load_val(load_val),
      .remain(remain_sec),
      .at_one(at_one)
   );

   always_comb begin
      is_green = state == NS_GREEN || state == EW_GREEN;
      // "own" is the approach that holds (or is about to receive) the green
      own = (state == NS_GREEN || state == ALLRED_B) ? ns_dense : ew_dense;
      oth = (state == NS_GREEN || state == ALLRED_B) ? ew_dense : ns_dense;
      extend = is_green && own && !oth && !ped_pend && (int'(elapsed) + EXT_STEP <= GREEN_MAX);
      cut = is_green && ped_pend && remain_sec > CNT_W'(PED_CUT);
      adv = tick_sec && at_one && !extend;
      state_nx = adv ? next_phase(state) : state;
      load_val = cut ? CNT_W'(PED_CUT) :
                 extend ? CNT_W'(EXT_STEP) :
                 (state_nx == NS_GREEN || state_nx == EW_GREEN) ? (own ? CNT_W'(GREEN_LONG) : CNT_W'(GREEN_SHORT)) :
                 (state_nx == NS_YELLOW || state_nx == EW_YELLOW) ? CNT_W'(YELLOW_T) : CNT_W'(ALLRED_T);
      elapsed_nx = !tick_sec ? elapsed :
                   adv ? CNT_W'(1) :
                   (is_green && !at_one && !cut) ? elapsed + CNT_W'(1) : elapsed;
      ack_nx = adv && (state_nx == ALLRED_A || state_nx == ALLRED_B) && ped_pend;
      ped_nx = ped_req || (ped_pend && !ack_nx);
      ns_nx = state_nx == NS_GREEN ? GREEN : state_nx == NS_YELLOW ? YELLOW : RED;
      ew_nx = state_nx == EW_GREEN ? GREEN : state_nx == EW_YELLOW ? YELLOW : RED;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= ALLRED_B;
         ns_light    <= RED;
         ew_light    <= RED;
         elapsed     <= '0;
         ped_pend    <= 1'b0;
         phase_valid <= 1'b0;
         ped_ack     <= 1'b0;
      end else begin
         state       <= state_nx;
         ns_light    <= ns_nx;
         ew_light    <= ew_nx;
         elapsed     <= elapsed_nx;
         ped_pend    <= ped_nx;
         phase_valid <= adv;
         ped_ack     <= ack_nx;
      end

   assign phase = state;
endmodule
